// File: rtl/inv_psi_table_gen.sv
// Inverse twiddle table generator: builds PSI_INV^brv(k) mod Q into an N-entry
// register file by iterated multiply / bit-serial restoring reduction, then serves registered reads.
module inv_psi_table_gen #(
  parameter int unsigned LOGN    = 3,
  parameter int unsigned W       = 17,
  parameter int unsigned Q       = 257,
  parameter int unsigned PSI_INV = 193
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            ready,
  input  logic [LOGN-1:0] rd_addr,
  output logic [W-1:0]    rd_data
);

  localparam int unsigned N   = 1 << LOGN;
  localparam int unsigned BCW = $clog2(2 * W);

  localparam logic [W-1:0]    PSI_W  = W'(PSI_INV);
  localparam logic [W+1:0]    QX     = (W + 2)'(Q);
  localparam logic [BCW-1:0]  BC_TOP = BCW'(2 * W - 1);
  localparam logic [LOGN-1:0] K_LAST = LOGN'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_MUL,
    S_RED,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [W-1:0]      acc;
  logic [LOGN-1:0]   k;
  logic [2*W-1:0]    prod;
  logic [W:0]        rem;
  logic [BCW-1:0]    bc;

  logic [W+1:0]      t;
  logic [W:0]        red;

  logic [W-1:0]      mem [N];

  function automatic logic [LOGN-1:0] brv(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOGN; i++) begin
      r[i] = x[LOGN-1-i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_STORE;
      S_STORE: state_nx = (k == K_LAST) ? S_DONE : S_MUL;
      S_MUL:   state_nx = S_RED;
      S_RED:   if (bc == '0) state_nx = S_STORE;
      S_DONE:  if (start) state_nx = S_STORE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    unique case (state)
      S_STORE, S_MUL, S_RED: busy  = 1'b1;
      S_DONE:                ready = 1'b1;
      default: begin
        busy  = 1'b0;
        ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring reduction step: shift in one product bit, subtract Q if it fits.
  // rem stays below Q, so t < 2Q and one conditional subtract suffices.
  // ---------------------------------------------------------------------------
  always_comb begin
    t   = {rem, prod[bc]};
    red = (t >= QX) ? (W + 1)'(t - QX) : t[W:0];
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= W'(1);
      k    <= '0;
      prod <= '0;
      rem  <= '0;
      bc   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc <= W'(1);
            k   <= '0;
          end
        end
        S_MUL: begin
          prod <= (2 * W)'(acc) * (2 * W)'(PSI_W);
          rem  <= '0;
          bc   <= BC_TOP;
        end
        S_RED: begin
          rem <= red;
          bc  <= bc - BCW'(1);
          if (bc == '0) begin
            acc <= red[W-1:0];
            k   <= k + LOGN'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage and registered read port (read returns pre-write contents)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (state == S_STORE) begin
        mem[brv(k)] <= acc;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: doc/inv_psi_table_gen.md
Name: inv_psi_table_gen

Overview:
- Sequential generator and server of inverse twiddle factors for the INTT path. It is the counterpart of the forward psi twiddle ROM.
- On start it computes PSI_INV^brv(k) mod Q for k = 0..N-1 by iterated modular multiplication and writes each result to bit-reversed address brv(k) of an internal N-entry register file.
- It then serves registered reads to the inverse butterfly controller.
- Defaults (N=8, Q=257, PSI_INV=193 = 4^-1 mod 257) produce the table 1, 256, 241, 16, 193, 64, 253, 4 (addr 0..7).

Parameters:
- LOGN, 3, log2 of table depth; N = 2^LOGN entries; brv() reverses LOGN bits
- W, 17, coefficient width; Q < 2^W
- Q, 257, modulus
- PSI_INV, 193, inverse primitive root (already reduced, < Q)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; request (re)generation of the table
- busy  output  1  high while generation is in progress
- ready  output  1  high when the table is complete and valid
- rd_addr  input  LOGN  read address
- rd_data  output  W  registered read data, mem[rd_addr], 1-cycle latency

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0; ready=0; rd_data=0; all mem entries=0; acc=1; k=0; product and remainder registers=0.
- Datapath registers:
  - acc (W bits)
  - k (LOGN bits)
  - prod (2W bits) = acc*PSI_INV, full width, no truncation
  - rem (W+1 bits)
  - bit counter bc (counts 2W cycles)
- State IDLE: start=1 at an edge -> STORE; acc=1, k=0, busy=1.
- State STORE (1 cycle): mem[brv(k)] <= acc.
  - If k==N-1 -> DONE (busy=0, ready=1).
  - Else -> MUL.
- State MUL (1 cycle): prod <= acc*PSI_INV; rem <= 0; bc <= 2W-1 -> RED.
- State RED (exactly 2W cycles): restoring reduction, MSB first.
  - t = {rem, prod[bc]}; rem <= (t >= Q) ? t-Q : t.
  - On the final cycle (bc==0): acc <= reduced result; k <= k+1 -> STORE.
- State DONE: hold ready=1. start=1 -> STORE with acc=1, k=0, busy=1, ready=0. Old mem contents are not cleared.
- Timing: with start sampled at edge E0, entry k is written at edge E(1 + k*(2W+2)). With defaults that is E1, E37, ..., E253; ready rises at E253.
- Every stored value is fully reduced (< Q).
- Read port: rd_data <= mem[rd_addr] on every edge, regardless of state.
  - Data is guaranteed only when ready was high at the sampling edge.
  - Reads during generation return whatever mem currently holds.
  - A read and a STORE to the same address in the same edge return the old value.
- start while busy=1: ignored, with no effect on state or counters.
- rst asserted mid-generation: immediate return to the reset state; ready=0; mem cleared.
- busy and ready are never both high.

Test Plan:
- Reset then idle 10 cycles -> busy=0, ready=0, rd_data=0 for every rd_addr.
- Pulse start at E0 -> busy=1 from E0 to E253; ready=1 after E253; reads of addr 0..7 return 1, 256, 241, 16, 193, 64, 253, 4, each one cycle after the address is applied.
- Generation cycle check -> mem[brv(k)] written exactly at E1+36k; mem[4] (k=1) = 193 appears at E37, not earlier.
- Pulse start again at E100 while busy -> ignored; ready still rises at E253; table values unchanged.
- Assert rst at E120 -> busy=0, ready=0 and all reads return 0 asynchronously. Then pulse start -> full table regenerated correctly 253 edges later.
- Pulse start in DONE -> ready=0 at the next edge, busy=1; table regenerated with identical values; ready re-asserts 253 edges after that start.
